decoder_round_controller: RTL and testbench
===========================================

# decoder_round_controller

Sequences one decoding round of the single-FPGA union-find grid decoder. It accepts a syndrome frame from upstream and drives `measurement_valid`. It then times the settle window and the `start_offer`/`stop_offer` window. Afterwards it scans the grid's per-node matched flags and match values, and streams one result per matched stabilizer to a downstream consumer. It sits between the syndrome source and the stabilizer grid top, replacing bench-driven pulse sequencing.

## Interface

- GRID_HEIGHT, 2, stabilizer rows
- GRID_WIDTH, 3, stabilizer columns
- CORDINATE_WIDTH, 3, bits per y or x coordinate; MATCH_VALUE_WIDTH = 2*CORDINATE_WIDTH
- LOAD_SETTLE_CYCLES, 100, cycles between measurement_valid and start_offer (>=1)
- OFFER_CYCLES, 2500, cycles between start_offer and stop_offer (>=1)
- CNT_WIDTH, 16, window counter width; must hold max(LOAD_SETTLE_CYCLES, OFFER_CYCLES)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- syndrome_in  in  H*W  syndrome bits, index = y*GRID_WIDTH + x
- syndrome_valid  in  1  upstream frame valid
- syndrome_ready  out  1  controller idle, frame accepted on valid&&ready
- measurement_value_out  out  H*W  captured syndrome, held for the whole round
- measurement_valid_out  out  1  one-cycle load pulse to grid
- start_offer  out  1  one-cycle pulse
- stop_offer  out  1  one-cycle pulse
- measurement_in  in  H*W  per-node matched flag from grid
- match_value_in  in  H*W*MATCH_VALUE_WIDTH  per-node match value {y,x}, node i at slice i
- result_valid  out  1  result available
- result_ready  in  1  downstream accepts
- result_y, result_x  out  CORDINATE_WIDTH each  source node coordinate
- result_match  out  MATCH_VALUE_WIDTH  match value {y,x} of that node
- round_done  out  1  one-cycle pulse at end of round
- round_count  out  16  completed rounds, wraps at 2^16

## Operation

- FSM states: IDLE, LOAD, SETTLE, OFFER_START, OFFER, STOP, SCAN, EMIT, DONE. All outputs are decoded from registered state and registered data; there are no combinational input-to-output paths except syndrome_ready = (state==IDLE).
- IDLE: on syndrome_valid, capture syndrome_in into measurement_value_out and go to LOAD.
- LOAD: measurement_valid_out=1; load the counter with LOAD_SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the counter; at zero go to OFFER_START.
- OFFER_START: start_offer=1; load the counter with OFFER_CYCLES-1; go to OFFER.
- OFFER: decrement the counter; at zero go to STOP.
- STOP: stop_offer=1; clear the scan index; go to SCAN.
- SCAN: each cycle, examine measurement_in[idx].
  - If set, latch y, x and match_value_in[idx] into the result registers and go to EMIT.
  - Else, if idx is the last node go to DONE; otherwise increment idx.
- EMIT: result_valid=1, with the result registers stable. On result_ready, go to SCAN with idx+1, or to DONE if idx was the last node.
- DONE: round_done=1; round_count increments; go to IDLE.
- Scan order is row-major (y outer, x inner). Results are emitted only for nodes with the matched flag set.
- syndrome_valid outside IDLE is ignored; upstream must hold it.
- measurement_in and match_value_in are sampled only in SCAN, after stop_offer.

## Timing

- Reset values: state IDLE, syndrome_ready=1, measurement_value_out=0, all pulses 0, result_valid=0, result_* = 0, round_count=0.
- Accept at cycle 0 produces:
  - measurement_valid_out at cycle 1
  - start_offer at cycle LOAD_SETTLE_CYCLES+2
  - stop_offer at cycle LOAD_SETTLE_CYCLES+OFFER_CYCLES+3
- SCAN costs 1 cycle per node; EMIT costs at least 1 cycle per matched node.
- With no matched nodes, round_done fires H*W+1 cycles after stop_offer, and syndrome_ready is high on the following cycle.
- Reset asserted mid-round forces all outputs to reset values immediately. No trailing stop_offer is emitted.

## Configuration

- DECODER_ROUND_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - abort high in SETTLE, OFFER_START or OFFER moves to STOP next cycle; stop_offer is still pulsed.
  - The controller then goes directly to DONE, skipping SCAN. round_done pulses, round_count does not increment, and no results are emitted.
  - abort is ignored in all other states.
- Undefined: the port is absent and windows always run to completion.

## Structure

- Package decoder_ctrl_pkg: FSM state enum, MATCH_VALUE_WIDTH derivation, index-to-(y,x) helper function.
- One sub-module, round_cycle_counter: a loadable CNT_WIDTH down-counter with a zero flag, instantiated once and shared by SETTLE and OFFER.

## Test plan

- Reset: hold reset low for 10 cycles → all outputs at reset values, syndrome_ready=1, round_count=0.
- Nominal round (LOAD_SETTLE_CYCLES=4, OFFER_CYCLES=8):
  - Stimulus: syndrome 6'b000011 accepted at cycle 0; measurement_in=6'b000011; node0 match {0,1}, node1 match {0,0}; result_ready=1.
  - Response: measurement_valid_out at cycle 1, start_offer at cycle 6, stop_offer at cycle 15.
  - Results: (0,0,{0,1}) then (0,1,{0,0}).
  - round_done pulses, round_count=1.
- Backpressure: same round with result_ready low for 5 cycles during the first EMIT → result_valid and data stable throughout, no index advance, both results eventually delivered in order.
- Empty round: measurement_in=0 → no result_valid; round_done exactly 7 cycles after stop_offer; syndrome_ready high the next cycle; valid held during the round is not accepted early.
- Reset mid-OFFER: assert reset at cycle 10 → outputs cleared asynchronously, no stop_offer; after release, a new frame is accepted and runs a full round.
- Abort (macro defined): assert abort at cycle 8 → stop_offer at cycle 9, round_done at cycle 10, no results, round_count unchanged.

Source files
------------

// File: rtl/decoder_ctrl_pkg.sv
// Shared types and helpers for the union-find decoder round controller.
// Provides the FSM state enum, match-value width derivation, node index split.
package decoder_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SETTLE,
        OFFER_START,
        OFFER,
        STOP,
        SCAN,
        EMIT,
        DONE
    } round_state_t;

    // A match value packs {y, x}, one coordinate each.
    function automatic int match_value_width(input int cord_width);
        return 2 * cord_width;
    endfunction

    // Row-major node numbering: idx = y*width + x.
    function automatic int node_y(input int idx, input int width);
        return idx / width;
    endfunction

    function automatic int node_x(input int idx, input int width);
        return idx % width;
    endfunction

endpackage

// File: rtl/round_cycle_counter.sv
// Loadable down-counter that times the settle and offer windows.
// Ports: clk, reset (async active-low), load/load_value, dec, zero flag.
module round_cycle_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder_round_controller.sv
// Sequences one decoding round: capture, load, settle, offer window, scan, emit.
// Optional abort input when DECODER_ROUND_ABORT_EN is defined.
module decoder_round_controller
    import decoder_ctrl_pkg::*;
#(
    parameter int GRID_HEIGHT        = 2,
    parameter int GRID_WIDTH         = 3,
    parameter int CORDINATE_WIDTH    = 3,
    parameter int LOAD_SETTLE_CYCLES = 100,
    parameter int OFFER_CYCLES       = 2500,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                   syndrome_in,
    input  logic                                                syndrome_valid,
    output logic                                                syndrome_ready,
    output logic [GRID_HEIGHT*GRID_WIDTH-1:0]                   measurement_value_out,
    output logic                                                measurement_valid_out,
    output logic                                                start_offer,
    output logic                                                stop_offer,
    input  logic [GRID_HEIGHT*GRID_WIDTH-1:0]                   measurement_in,
    input  logic [GRID_HEIGHT*GRID_WIDTH*2*CORDINATE_WIDTH-1:0] match_value_in,
`ifdef DECODER_ROUND_ABORT_EN
    input  logic                                                abort,
`endif
    output logic                                                result_valid,
    input  logic                                                result_ready,
    output logic [CORDINATE_WIDTH-1:0]                          result_y,
    output logic [CORDINATE_WIDTH-1:0]                          result_x,
    output logic [2*CORDINATE_WIDTH-1:0]                        result_match,
    output logic                                                round_done,
    output logic [15:0]                                         round_count
);

    localparam int MVW   = match_value_width(CORDINATE_WIDTH);
    localparam int NODES = GRID_HEIGHT * GRID_WIDTH;
    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

    round_state_t state, state_n;

    logic [IDX_W-1:0]     idx;
    logic                 last;
    logic                 hit;
    logic                 aborted_q;
    logic                 abort_take;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic [CNT_WIDTH-1:0] cnt_value;

    round_cycle_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign last = (idx == IDX_W'(NODES - 1));
    assign hit  = measurement_in[idx];

    always_comb begin
        state_n    = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_value  = '0;
        abort_take = 1'b0;
        unique case (state)
            IDLE: if (syndrome_valid) state_n = LOAD;
            LOAD: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_WIDTH'(LOAD_SETTLE_CYCLES - 1);
                state_n   = SETTLE;
            end
            SETTLE: begin
                if (cnt_zero) state_n = OFFER_START;
                else          cnt_dec = 1'b1;
            end
            OFFER_START: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_WIDTH'(OFFER_CYCLES - 1);
                state_n   = OFFER;
            end
            OFFER: begin
                if (cnt_zero) state_n = STOP;
                else          cnt_dec = 1'b1;
            end
            // An aborted round still pulses stop_offer but skips the scan.
            STOP: state_n = aborted_q ? DONE : SCAN;
            SCAN: begin
                if (hit)       state_n = EMIT;
                else if (last) state_n = DONE;
            end
            EMIT: if (result_ready) state_n = last ? DONE : SCAN;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef DECODER_ROUND_ABORT_EN
        if (abort && (state == SETTLE || state == OFFER_START || state == OFFER)) begin
            state_n    = STOP;
            abort_take = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            idx                   <= '0;
            aborted_q             <= 1'b0;
            measurement_value_out <= '0;
            result_y              <= '0;
            result_x              <= '0;
            result_match          <= '0;
            round_count           <= '0;
        end else begin
            state <= state_n;
            if (abort_take) aborted_q <= 1'b1;
            else if (state == DONE) aborted_q <= 1'b0;
            if (state == IDLE && syndrome_valid) measurement_value_out <= syndrome_in;
            if (state == STOP) idx <= '0;
            if (state == SCAN) begin
                if (hit) begin
                    result_y     <= CORDINATE_WIDTH'(node_y(int'(idx), GRID_WIDTH));
                    result_x     <= CORDINATE_WIDTH'(node_x(int'(idx), GRID_WIDTH));
                    result_match <= match_value_in[int'(idx)*MVW +: MVW];
                end else if (!last) begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == EMIT && result_ready && !last) idx <= idx + 1'b1;
            if (state == DONE && !aborted_q) round_count <= round_count + 16'd1;
        end
    end

    assign syndrome_ready        = (state == IDLE);
    assign measurement_valid_out = (state == LOAD);
    assign start_offer           = (state == OFFER_START);
    assign stop_offer            = (state == STOP);
    assign result_valid          = (state == EMIT);
    assign round_done            = (state == DONE);

endmodule

// File: tb/tb_decoder_round_controller.sv
// Directed bench for decoder_round_controller with short windows (4 / 8).
// Cycle 0 is the accepting cycle; outputs sampled 1 time unit after posedge.
module tb_decoder_round_controller;

    localparam int H   = 2;
    localparam int W   = 3;
    localparam int CW  = 3;
    localparam int LS  = 4;
    localparam int OC  = 8;
    localparam int N   = H * W;
    localparam int MVW = 2 * CW;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     syndrome_in;
    logic             syndrome_valid;
    logic             syndrome_ready;
    logic [N-1:0]     measurement_value_out;
    logic             measurement_valid_out;
    logic             start_offer;
    logic             stop_offer;
    logic [N-1:0]     measurement_in;
    logic [N*MVW-1:0] match_value_in;
    logic             abort;
    logic             result_valid;
    logic             result_ready;
    logic [CW-1:0]    result_y;
    logic [CW-1:0]    result_x;
    logic [MVW-1:0]   result_match;
    logic             round_done;
    logic [15:0]      round_count;

    decoder_round_controller #(
        .GRID_HEIGHT        (H),
        .GRID_WIDTH         (W),
        .CORDINATE_WIDTH    (CW),
        .LOAD_SETTLE_CYCLES (LS),
        .OFFER_CYCLES       (OC),
        .CNT_WIDTH          (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .syndrome_in           (syndrome_in),
        .syndrome_valid        (syndrome_valid),
        .syndrome_ready        (syndrome_ready),
        .measurement_value_out (measurement_value_out),
        .measurement_valid_out (measurement_valid_out),
        .start_offer           (start_offer),
        .stop_offer            (stop_offer),
        .measurement_in        (measurement_in),
        .match_value_in        (match_value_in),
`ifdef DECODER_ROUND_ABORT_EN
        .abort                 (abort),
`endif
        .result_valid          (result_valid),
        .result_ready          (result_ready),
        .result_y              (result_y),
        .result_x              (result_x),
        .result_match          (result_match),
        .round_done            (round_done),
        .round_count           (round_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int mv_c, start_c, stop_c, done_c;
    int n_start, n_stop;
    int nres, early_rdy, hold_bad, unstable, stalled;
    logic [CW-1:0]  res_y [4];
    logic [CW-1:0]  res_x [4];
    logic [MVW-1:0] res_m [4];
    logic [CW+CW+MVW-1:0] snap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_round(input logic [N-1:0] syn, input logic [N-1:0] meas,
                             input int stall, input bit hold_valid, input int abort_at);
        measurement_in = meas;
        mv_c = -1; start_c = -1; stop_c = -1; done_c = -1;
        n_start = 0; n_stop = 0;
        nres = 0; early_rdy = 0; hold_bad = 0; unstable = 0; stalled = 0;
        syndrome_in    = syn;
        syndrome_valid = 1'b1;
        tick();
        if (!hold_valid) syndrome_valid = 1'b0;
        for (int c = 1; c < 400 && done_c < 0; c++) begin
            if (measurement_valid_out) mv_c = c;
            if (start_offer) begin start_c = c; n_start++; end
            if (stop_offer) begin stop_c = c; n_stop++; end
            if (round_done) done_c = c;
            if (syndrome_ready) early_rdy++;
            if (measurement_value_out != syn) hold_bad++;
            abort = (c == abort_at);
            result_ready = 1'b1;
            if (result_valid) begin
                if (nres == 0 && stalled < stall) begin
                    result_ready = 1'b0;
                    if (stalled == 0) snap = {result_y, result_x, result_match};
                    else if (snap != {result_y, result_x, result_match}) unstable++;
                    stalled++;
                end else begin
                    if (nres < 4) begin
                        res_y[nres] = result_y;
                        res_x[nres] = result_x;
                        res_m[nres] = result_match;
                    end
                    nres++;
                end
            end
            tick();
        end
        abort = 1'b0;
        check("round_timeout", done_c >= 0, 1);
        check("ready_after_done", syndrome_ready, 1);
        syndrome_valid = 1'b0;
    endtask

    task automatic check_results(input string pfx);
        check({pfx, "_nres"}, nres, 2);
        check({pfx, "_r0_y"}, res_y[0], 0);
        check({pfx, "_r0_x"}, res_x[0], 0);
        check({pfx, "_r0_m"}, res_m[0], 6'b000_001);
        check({pfx, "_r1_y"}, res_y[1], 0);
        check({pfx, "_r1_x"}, res_x[1], 1);
        check({pfx, "_r1_m"}, res_m[1], 6'b000_000);
    endtask

    initial begin
        reset          = 1'b0;
        syndrome_in    = '0;
        syndrome_valid = 1'b0;
        measurement_in = '0;
        abort          = 1'b0;
        result_ready   = 1'b1;
        // node0 {0,1}, node1 {0,0}, remaining nodes carry distinct decoys
        match_value_in = {6'o55, 6'o44, 6'o33, 6'o22, 6'o00, 6'o01};

        repeat (10) tick();
        check("rst_ready", syndrome_ready, 1);
        check("rst_meas_val", measurement_value_out, 0);
        check("rst_pulses", {measurement_valid_out, start_offer, stop_offer, round_done}, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", {result_y, result_x, result_match}, 0);
        check("rst_round_count", round_count, 0);
        reset = 1'b1;
        tick();

        // Nominal round
        run_round(6'b000011, 6'b000011, 0, 1'b0, -1);
        check("nom_mv_cycle", mv_c, 1);
        check("nom_start_cycle", start_c, 6);
        check("nom_stop_cycle", stop_c, 15);
        check("nom_done_cycle", done_c, 24);
        check("nom_pulse_counts", {n_start[7:0], n_stop[7:0]}, 16'h0101);
        check("nom_meas_hold", hold_bad, 0);
        check_results("nom");
        check("nom_round_count", round_count, 1);

        // Backpressure on the first result
        run_round(6'b000011, 6'b000011, 5, 1'b0, -1);
        check("bp_stalled", stalled, 5);
        check("bp_stable", unstable, 0);
        check("bp_snap", snap, {3'd0, 3'd0, 6'b000_001});
        check("bp_done_cycle", done_c, 29);
        check_results("bp");
        check("bp_round_count", round_count, 2);

        // Empty round, valid held throughout
        run_round(6'b101101, 6'b000000, 0, 1'b1, -1);
        check("empty_nres", nres, 0);
        check("empty_done_gap", done_c - stop_c, 7);
        check("empty_early_ready", early_rdy, 0);
        check("empty_meas_hold", hold_bad, 0);
        check("empty_round_count", round_count, 3);

`ifdef DECODER_ROUND_ABORT_EN
        run_round(6'b000011, 6'b000011, 0, 1'b0, 8);
        check("abort_stop_cycle", stop_c, 9);
        check("abort_done_cycle", done_c, 10);
        check("abort_nres", nres, 0);
        check("abort_round_count", round_count, 3);
`endif

        // Reset mid-OFFER at cycle 10
        measurement_in = 6'b000011;
        syndrome_in    = 6'b000011;
        syndrome_valid = 1'b1;
        tick();
        syndrome_valid = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ready", syndrome_ready, 1);
        check("mid_rst_meas_val", measurement_value_out, 0);
        check("mid_rst_pulses", {measurement_valid_out, start_offer, stop_offer, round_done}, 0);
        check("mid_rst_round_count", round_count, 0);
        n_stop = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (stop_offer) n_stop++;
        end
        check("mid_rst_no_stop", n_stop, 0);
        reset = 1'b1;
        tick();

        run_round(6'b000011, 6'b000011, 0, 1'b0, -1);
        check("post_rst_stop_cycle", stop_c, 15);
        check_results("post_rst");
        check("post_rst_round_count", round_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
